// File: rtl/inv_round_column_sequencer.sv
// Column-serial decryption round stage: AddRoundKey on a 128-bit state, then
// inverse MixColumns one 32-bit column per cycle (bypassed on the final round).
module inv_round_column_sequencer #(
  parameter int NCOL = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] state_in,
  input  logic [127:0] round_key,
  input  logic         skip_mix,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] state_out,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, MIX, DONE} state_t;

  localparam logic [1:0] LAST_COL = 2'(NCOL - 1);

  state_t       state_q;
  logic [1:0]   col_q;
  logic [127:0] buf_q;
  logic         out_valid_q;
  logic [127:0] state_out_q;
  logic         busy_q;
  logic         in_ready_q;

  logic [31:0]  rc;
  logic [31:0]  mcl;
  logic [127:0] buf_mix;
  logic [127:0] buf_key;

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
    logic [7:0] a [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    logic [7:0] x2, x4, x8;
    for (int i = 0; i < 4; i++) begin
      a[i]  = c[31-8*i -: 8];
      x2    = xt(a[i]);
      x4    = xt(x2);
      x8    = xt(x4);
      m9[i] = x8 ^ a[i];
      mb[i] = x8 ^ x2 ^ a[i];
      md[i] = x8 ^ x4 ^ a[i];
      me[i] = x8 ^ x4 ^ x2;
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  // Helper input is the buffer column selected by col; column 0 sits in the MSBs.
  always_comb begin
    rc      = 32'd0;
    buf_mix = buf_q;
    case (col_q)
      2'd0: rc = buf_q[127:96];
      2'd1: rc = buf_q[95:64];
      2'd2: rc = buf_q[63:32];
      default: rc = buf_q[31:0];
    endcase
    mcl = inv_mix_col(rc);
    case (col_q)
      2'd0: buf_mix[127:96] = mcl;
      2'd1: buf_mix[95:64]  = mcl;
      2'd2: buf_mix[63:32]  = mcl;
      default: buf_mix[31:0] = mcl;
    endcase
  end

  assign buf_key = state_in ^ round_key;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      col_q       <= 2'd0;
      buf_q       <= '0;
      out_valid_q <= 1'b0;
      state_out_q <= '0;
      busy_q      <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            buf_q      <= buf_key;
            col_q      <= 2'd0;
            busy_q     <= 1'b1;
            in_ready_q <= 1'b0;
            if (skip_mix) begin
              state_q     <= DONE;
              out_valid_q <= 1'b1;
              state_out_q <= buf_key;
            end else begin
              state_q <= MIX;
            end
          end
        end
        MIX: begin
          buf_q <= buf_mix;
          col_q <= col_q + 2'd1;
          // Output register is loaded together with the last column so no partial state is exposed.
          if (col_q == LAST_COL) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
            state_out_q <= buf_mix;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign state_out = state_out_q;
  assign busy      = busy_q;

endmodule
